// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared read-owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;
  function automatic int streak_w(input int max_streak);
    return max_streak > 0 ? $clog2(max_streak + 1) : 1;
  endfunction
endpackage

// File: rtl/arb_streak_counter.sv
// arb_streak_counter: saturating data-grant streak counter with clear and max flag
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam int W = streak_w(MAX);
  logic [W-1:0] r_cnt;
  assign o_at_max = r_cnt >= W'(MAX);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_at_max) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between fetch and load/store with data priority
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);
  logic   w_at_max;
  logic   w_dm_rd;
  owner_e r_owner;
  logic   r_flush;
  arb_streak_counter #(.MAX(MAX_DM_STREAK)) u_streak (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (o_dm_gnt & i_if_req),
    .i_clr    (o_if_gnt | ~i_if_req),
    .o_at_max (w_at_max)
  );
  always_comb begin
    o_dm_gnt    = i_dm_req & (~i_if_req | ~w_at_max);
    o_if_gnt    = i_if_req & ~o_dm_gnt;
    w_dm_rd     = o_dm_gnt & ~i_dm_we;
    o_mem_wen   = o_dm_gnt & i_dm_we;
    o_mem_ren   = o_if_gnt | w_dm_rd;
    o_mem_addr  = o_dm_gnt ? i_dm_addr : o_if_gnt ? i_if_addr : '0;
    o_mem_wdata = o_mem_wen ? i_dm_wdata : '0;
    o_mem_mask  = o_mem_wen ? i_dm_mask : o_mem_ren ? 4'hF : 4'h0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= OWN_NONE;
      r_flush <= 1'b0;
    end else begin
      r_owner <= o_if_gnt ? OWN_IF : w_dm_rd ? OWN_DM : OWN_NONE;
      r_flush <= o_if_gnt & i_if_flush;
    end
  end
  assign o_if_rvalid = (r_owner == OWN_IF) & ~r_flush;
  assign o_dm_rvalid = r_owner == OWN_DM;
  assign o_if_rdata  = i_mem_rdata;
  assign o_dm_rdata  = i_mem_rdata;
endmodule
